mult_sequencer: RTL and testbench
=================================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of multiplier bits and shift-add iterations (N >= 2).
REQ-002 SHALL have port sys_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request one multiplication; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous cancel of an operation in progress.
REQ-006 SHALL have port flag  input  1  current multiplier LSB from the datapath shift register.
REQ-007 SHALL have port enA, enB  output  1 each  load the operand registers.
REQ-008 SHALL have port clrACC, enACC  output  1 each  clear and load the accumulator.
REQ-009 SHALL have port enSR, SRsel  output  1 each  shift-register enable; SRsel=1 parallel load, SRsel=0 shift right.
REQ-010 SHALL have port alu_op  output  3  ALU operation; 3'b001 = add, 3'b000 = pass.
REQ-011 SHALL have port enDPO  output  1  load the product output register.
REQ-012 SHALL have port busy, done  output  1 each  operation in progress, and a one-cycle completion pulse.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, LOAD, TEST, ADD, SHIFT, STORE, DONE; every output SHALL be decoded from state only.
REQ-014 SHALL hold an iteration counter of clog2(N) bits, cleared in LOAD and incremented on each SHIFT exit.
REQ-015 IDLE: all outputs 0; start=1 -> LOAD, else stay in IDLE.
REQ-016 LOAD: enA=enB=clrACC=enSR=SRsel=1 for one cycle -> TEST.
REQ-017 TEST: all strobes 0; flag=1 -> ADD, flag=0 -> SHIFT; flag SHALL be ignored in every other state.
REQ-018 ADD: alu_op=3'b001, enACC=1 for one cycle -> SHIFT.
REQ-019 SHIFT: enSR=1, SRsel=0, alu_op=3'b000, enACC=1 (accumulator shifts with the shift register).
REQ-020 SHIFT exit: counter==N-1 -> STORE, else -> TEST.
REQ-021 STORE: enDPO=1 for one cycle -> DONE.
REQ-022 DONE: done=1 for exactly one cycle -> IDLE unconditionally.
REQ-023 busy SHALL be 1 in every state except IDLE, including DONE.
REQ-024 Latency: done SHALL assert exactly 2N + popcount(multiplier) + 2 rising edges after the edge that accepts start.
REQ-025 start while busy=1 SHALL be ignored and not queued; start held high through DONE SHALL be accepted on the IDLE edge that follows DONE.
REQ-026 abort=1 in any state other than IDLE or DONE SHALL force IDLE on the next edge, with no done pulse and no enDPO pulse.
REQ-027 abort takes priority over every other transition; abort in IDLE or DONE SHALL have no effect.
REQ-028 Strobe exclusivity: enDPO SHALL never assert in the same cycle as enACC or enSR, and clrACC SHALL assert only in LOAD.

Reset
REQ-029 sys_rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, and every output 0.
REQ-030 Reset asserted mid-operation SHALL discard that operation; no done pulse SHALL follow reset release.
REQ-031 After sys_rst falls, start SHALL be accepted on the first rising edge.

Verification
REQ-032 Reset: assert sys_rst between clock edges -> all outputs 0 before the next edge; busy=0.
REQ-033 N=4, flag held 0, start pulse -> LOAD, 4x(TEST,SHIFT), STORE, DONE; done exactly 10 edges after accept; enACC high only in SHIFT cycles.
REQ-034 N=4, flag held 1 -> 4 ADD cycles each with alu_op=001; done at 14 edges; one enDPO pulse, in the cycle before done.
REQ-035 Multiplier 4'b0101, flag driven from the modelled shift register -> ADD visited in iterations 0 and 2 only; done at 12 edges.
REQ-036 start re-pulsed during TEST -> ignored, a single done pulse; abort during the second SHIFT -> IDLE next edge, no done, no enDPO.
REQ-037 start held high continuously -> back-to-back operations; IDLE occupied for one cycle between consecutive DONE and LOAD states.

Source files
------------

// File: rtl/mult_sequencer.sv
// Control sequencer for an N-bit shift-add multiplier datapath.
// Moore FSM: every strobe is a pure function of the current state.
module mult_sequencer #(
  parameter int unsigned N = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       abort,
  input  logic       flag,
  output logic       enA,
  output logic       enB,
  output logic       clrACC,
  output logic       enACC,
  output logic       enSR,
  output logic       SRsel,
  output logic [2:0] alu_op,
  output logic       enDPO,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ALU_W = 3;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    ADD,
    SHIFT,
    STORE,
    DONE
  } state_t;

  typedef struct packed {
    logic             en_a;
    logic             en_b;
    logic             clr_acc;
    logic             en_acc;
    logic             en_sr;
    logic             sr_sel;
    logic [ALU_W-1:0] alu_op;
    logic             en_dpo;
    logic             busy;
    logic             done;
  } ctrl_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            ctrl_q;
  logic             abortable_c;
  logic             last_iter_c;

  // Strobe table; registering decode(state_d) keeps outputs equal to decode(state_q).
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    c.busy = (s != IDLE);
    case (s)
      LOAD: begin
        c.en_a    = 1'b1;
        c.en_b    = 1'b1;
        c.clr_acc = 1'b1;
        c.en_sr   = 1'b1;
        c.sr_sel  = 1'b1;
      end
      ADD: begin
        c.alu_op = ALU_ADD;
        c.en_acc = 1'b1;
      end
      SHIFT: begin
        c.en_sr  = 1'b1;
        c.sr_sel = 1'b0;
        c.alu_op = ALU_PASS;
        c.en_acc = 1'b1;
      end
      STORE: c.en_dpo = 1'b1;
      DONE:  c.done   = 1'b1;
      default: c = c;
    endcase
    return c;
  endfunction

  assign abortable_c = (state_q != IDLE) && (state_q != DONE);
  assign last_iter_c = (cnt_q == LAST_ITER);

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = TEST;
      TEST:    state_d = flag ? ADD : SHIFT;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = last_iter_c ? STORE : TEST;
      STORE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && abortable_c) begin
      state_d = IDLE;
    end
  end

  // Iteration counter: cleared on load, advanced as each SHIFT is left
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else if (state_q == LOAD) begin
      cnt_q <= '0;
    end else if ((state_q == SHIFT) && !abort) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Output register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= decode(state_d);
    end
  end

  assign enA    = ctrl_q.en_a;
  assign enB    = ctrl_q.en_b;
  assign clrACC = ctrl_q.clr_acc;
  assign enACC  = ctrl_q.en_acc;
  assign enSR   = ctrl_q.en_sr;
  assign SRsel  = ctrl_q.sr_sel;
  assign alu_op = ctrl_q.alu_op;
  assign enDPO  = ctrl_q.en_dpo;
  assign busy   = ctrl_q.busy;
  assign done   = ctrl_q.done;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: each operation's expected phase
// sequence is built from the multiplier bits and compared cycle by cycle.
module tb_mult_sequencer;

  localparam int unsigned N = 4;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_TEST  = 2;
  localparam int P_ADD   = 3;
  localparam int P_SHIFT = 4;
  localparam int P_STORE = 5;
  localparam int P_DONE  = 6;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       start   = 1'b0;
  logic       abort   = 1'b0;
  logic       flag    = 1'b0;
  logic       enA, enB, clrACC, enACC, enSR, SRsel, enDPO, busy, done;
  logic [2:0] alu_op;
  logic [11:0] obs;

  int vectors     = 0;
  int miscompares = 0;

  mult_sequencer #(.N(N)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .start  (start),
    .abort  (abort),
    .flag   (flag),
    .enA    (enA),
    .enB    (enB),
    .clrACC (clrACC),
    .enACC  (enACC),
    .enSR   (enSR),
    .SRsel  (SRsel),
    .alu_op (alu_op),
    .enDPO  (enDPO),
    .busy   (busy),
    .done   (done)
  );

  always #5 sys_clk = ~sys_clk;

  assign obs = {enA, enB, clrACC, enACC, enSR, SRsel, alu_op, enDPO, busy, done};

  // {enA,enB,clrACC,enACC,enSR,SRsel,alu_op,enDPO,busy,done} for each phase
  function automatic logic [11:0] expect_out(input int p);
    case (p)
      P_LOAD:  return 12'b111011_000_010;
      P_TEST:  return 12'b000000_000_010;
      P_ADD:   return 12'b000100_001_010;
      P_SHIFT: return 12'b000110_000_010;
      P_STORE: return 12'b000000_000_110;
      P_DONE:  return 12'b000000_000_011;
      default: return 12'b000000_000_000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Starts one operation from IDLE; abort_k is the phase index to abort in (-1: none)
  task automatic run_op(input logic [N-1:0] m, input int abort_k);
    int q[$];
    int it;
    int first_done;
    int aborted;
    q.push_back(P_LOAD);
    for (int i = 0; i < int'(N); i++) begin
      q.push_back(P_TEST);
      if (m[i]) q.push_back(P_ADD);
      q.push_back(P_SHIFT);
    end
    q.push_back(P_STORE);
    q.push_back(P_DONE);

    check("idle_pre", 32'(obs), 32'(expect_out(P_IDLE)));
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    flag  = 1'($urandom_range(0, 1));
    it = 0;
    first_done = -1;
    aborted = 0;
    for (int k = 0; k < q.size(); k++) begin
      @(posedge sys_clk); #1;
      check($sformatf("op m=%0h k=%0d", m, k), 32'(obs), 32'(expect_out(q[k])));
      if (done && first_done < 0) first_done = k;
      start = 1'($urandom_range(0, 1));
      flag  = (q[k] == P_TEST) ? m[it] : 1'($urandom_range(0, 1));
      if (q[k] == P_SHIFT) it++;
      if (k == abort_k) begin
        abort = 1'b1;
        aborted = 1;
        break;
      end
      abort = (q[k] == P_DONE) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    if (aborted != 0) begin
      @(posedge sys_clk); #1;
      check($sformatf("abort_idle m=%0h k=%0d", m, abort_k), 32'(obs), 32'(expect_out(P_IDLE)));
      start = 1'b0;
      abort = 1'b0;
      repeat (3) begin
        @(posedge sys_clk); #1;
        check("abort_quiet", 32'(obs), 32'(expect_out(P_IDLE)));
      end
    end else begin
      check($sformatf("latency m=%0h", m), 32'(first_done),
            32'(2 * int'(N) + $countones(m) + 2));
      @(posedge sys_clk); #1;
      check("post_done_idle", 32'(obs), 32'(expect_out(P_IDLE)));
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  initial begin
    logic [N-1:0] m;
    int len;
    int ak;

    // Asynchronous reset between edges
    #2 sys_rst = 1'b1;
    #1 check("rst_async", 32'(obs), 32'(expect_out(P_IDLE)));
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Directed: first edge after release accepts; then back-to-back operations
    run_op(4'b0000, -1);
    run_op(4'b1111, -1);
    run_op(4'b0101, -1);
    run_op(4'b0000, 4);
    run_op(4'b1011, 0);

    // Reset mid-operation discards it
    start = 1'b1;
    @(posedge sys_clk); #1;
    check("rst_op_load", 32'(obs), 32'(expect_out(P_LOAD)));
    start = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    #1 check("rst_midop", 32'(obs), 32'(expect_out(P_IDLE)));
    @(posedge sys_clk); #1;
    check("rst_held", 32'(obs), 32'(expect_out(P_IDLE)));
    sys_rst = 1'b0;
    repeat (4) begin
      @(posedge sys_clk); #1;
      check("rst_quiet", 32'(obs), 32'(expect_out(P_IDLE)));
    end
    #2 sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    run_op(4'b0110, -1);

    // Randomized operations with occasional aborts and idle gaps
    for (int n = 0; n < 150; n++) begin
      m   = N'($urandom);
      len = 2 * int'(N) + $countones(m) + 3;
      ak  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 2)) : -1;
      run_op(m, ak);
      repeat ($urandom_range(0, 2)) begin
        @(posedge sys_clk); #1;
        check("idle_gap", 32'(obs), 32'(expect_out(P_IDLE)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
